mhd_serial_checker: RTL and testbench

Sequential Hamming-distance checker for approximate-circuit validation. It accepts a stream of output-vector pairs (exact, approximate) over a valid/ready handshake and computes each pair's Hamming distance chunk-serially on one shared CHUNK-bit popcount unit. It flags pairs whose distance exceeds a programmable threshold and keeps running statistics. It sits between the simulation vector source and the error-report logic, as the time-multiplexed counterpart of the combinational distance miter.

---
 rtl/mhd_pkg.sv | 16 +
 rtl/mhd_popcnt.sv | 21 ++
 rtl/mhd_serial_checker.sv | 137 +++++++++++++
 tb/tb_mhd_serial_checker.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mhd_pkg.sv
// Shared types and helpers for the serial Hamming-distance checker.
package mhd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int STAT_W = 32;

    function automatic int cw_of(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mhd_popcnt.sv
// Combinational population count of one CHUNK-bit slice.
module mhd_popcnt #(
    parameter int CHUNK = 8,
    parameter int PW    = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] i_bits,
    output logic [PW-1:0]    o_count
);

    logic [PW-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < CHUNK; i++) begin
            w_sum = w_sum + PW'(i_bits[i]);
        end
    end

    assign o_count = w_sum;

endmodule

// File: rtl/mhd_serial_checker.sv
// Chunk-serial Hamming-distance checker: one shared popcount unit, threshold
// flagging on a valid/ready result, and saturating running statistics.
module mhd_serial_checker
    import mhd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int CW    = cw_of(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [CW-1:0]     thresh,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     out_dist,
    output logic              out_viol,
    input  logic              clr_stats,
    output logic [STAT_W-1:0] stat_count,
    output logic [STAT_W-1:0] stat_viol,
    output logic [CW-1:0]     stat_max
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int PW  = $clog2(CHUNK + 1);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_diff;
    logic [CW-1:0]     r_thresh;
    logic [CW-1:0]     r_acc;
    logic [IW-1:0]     r_idx;
    logic [CW-1:0]     r_dist;
    logic              r_viol;
    logic [STAT_W-1:0] r_count;
    logic [STAT_W-1:0] r_nviol;
    logic [CW-1:0]     r_max;

    logic [CHUNK-1:0]  w_chunk;
    logic [PW-1:0]     w_pop;
    logic [CW-1:0]     w_acc_nxt;
    logic              w_viol_nxt;
    logic              w_last;
    logic              w_accept;
    logic              w_done;

    assign w_chunk    = r_diff[int'(r_idx)*CHUNK +: CHUNK];
    assign w_acc_nxt  = r_acc + CW'(w_pop);
    assign w_viol_nxt = (w_acc_nxt > r_thresh);
    assign w_last     = (r_idx == IW'(NCH - 1));
    assign w_accept   = (r_state == IDLE) && in_valid;
    assign w_done     = (r_state == ACCUM) && w_last;

    mhd_popcnt #(
        .CHUNK (CHUNK),
        .PW    (PW)
    ) u_popcnt (
        .i_bits  (w_chunk),
        .o_count (w_pop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = ACCUM;
            ACCUM:   if (w_last)    w_state_nxt = HOLD;
            HOLD:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Datapath: diff/thresh captured at acceptance so later input changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_diff   <= '0;
            r_thresh <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_dist   <= '0;
            r_viol   <= 1'b0;
        end else if (w_accept) begin
            r_diff   <= in_a ^ in_b;
            r_thresh <= thresh;
            r_acc    <= '0;
            r_idx    <= '0;
        end else if (r_state == ACCUM) begin
            r_acc <= w_acc_nxt;
            r_idx <= w_last ? '0 : r_idx + IW'(1);
            if (w_last) begin
                r_dist <= w_acc_nxt;
                r_viol <= w_viol_nxt;
            end
        end
    end

    // Statistics: a clear coinciding with completion drops that pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_nviol <= '0;
            r_max   <= '0;
        end else if (clr_stats) begin
            r_count <= '0;
            r_nviol <= '0;
            r_max   <= '0;
        end else if (w_done) begin
            r_count <= sat_inc(r_count);
            if (w_viol_nxt) r_nviol <= sat_inc(r_nviol);
            if (w_acc_nxt > r_max) r_max <= w_acc_nxt;
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == HOLD);
    assign out_dist   = r_dist;
    assign out_viol   = r_viol;
    assign stat_count = r_count;
    assign stat_viol  = r_nviol;
    assign stat_max   = r_max;

endmodule

// File: tb/tb_mhd_serial_checker.sv
// Directed bench for mhd_serial_checker with hand-computed expectations.
module tb_mhd_serial_checker;

    localparam int WIDTH = 32;
    localparam int CW    = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [CW-1:0]    thresh = 6'd12;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CW-1:0]    out_dist;
    logic             out_viol;
    logic             clr_stats = 1'b0;
    logic [31:0]      stat_count;
    logic [31:0]      stat_viol;
    logic [CW-1:0]    stat_max;

    int n_assert = 0;
    int n_fail   = 0;
    int lat;

    always #5 clk = ~clk;

    mhd_serial_checker #(.WIDTH(WIDTH), .CHUNK(8), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .thresh     (thresh),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dist   (out_dist),
        .out_viol   (out_viol),
        .clr_stats  (clr_stats),
        .stat_count (stat_count),
        .stat_viol  (stat_viol),
        .stat_max   (stat_max)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a pair and return just after the acceptance edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [CW-1:0] th);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("ready_before_send", {31'd0, in_ready}, 32'd1);
        in_a     = a;
        in_b     = b;
        thresh   = th;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_after_take", {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        repeat (2) tick();
        check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        tick();
        check("rst_dist",  {26'd0, out_dist}, 32'd0);
        check("rst_viol",  {31'd0, out_viol}, 32'd0);
        check("rst_count", stat_count, 32'd0);
        check("rst_sviol", stat_viol, 32'd0);
        check("rst_max",   {26'd0, stat_max}, 32'd0);

        // Identical vectors
        send(32'h0, 32'h0, 6'd12);
        wait_result(lat);
        check("zero_lat",   lat, 32'd4);
        check("zero_dist",  {26'd0, out_dist}, 32'd0);
        check("zero_viol",  {31'd0, out_viol}, 32'd0);
        check("zero_count", stat_count, 32'd1);
        check("zero_max",   {26'd0, stat_max}, 32'd0);
        take();

        // All bits differ
        send(32'hFFFF_FFFF, 32'h0, 6'd12);
        wait_result(lat);
        check("full_lat",   lat, 32'd4);
        check("full_dist",  {26'd0, out_dist}, 32'd32);
        check("full_viol",  {31'd0, out_viol}, 32'd1);
        check("full_sviol", stat_viol, 32'd1);
        check("full_max",   {26'd0, stat_max}, 32'd32);
        check("full_count", stat_count, 32'd2);
        take();

        // Threshold boundary: equal is not a violation
        send(32'h0000_0FFF, 32'h0, 6'd12);
        wait_result(lat);
        check("eq_dist", {26'd0, out_dist}, 32'd12);
        check("eq_viol", {31'd0, out_viol}, 32'd0);
        take();
        send(32'h0000_1FFF, 32'h0, 6'd12);
        wait_result(lat);
        check("gt_dist",  {26'd0, out_dist}, 32'd13);
        check("gt_viol",  {31'd0, out_viol}, 32'd1);
        check("gt_sviol", stat_viol, 32'd2);
        take();

        // Threshold changed after acceptance is ignored
        send(32'h0000_0FFF, 32'h0, 6'd12);
        thresh = 6'd0;
        wait_result(lat);
        check("thr_dist",  {26'd0, out_dist}, 32'd12);
        check("thr_viol",  {31'd0, out_viol}, 32'd0);
        check("thr_count", stat_count, 32'd5);
        check("thr_sviol", stat_viol, 32'd2);
        take();
        thresh = 6'd12;

        // Backpressure with a pending input
        send(32'h0000_00FF, 32'h0, 6'd12);
        wait_result(lat);
        check("bp_lat", lat, 32'd4);
        in_a     = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_ready", {31'd0, in_ready}, 32'd0);
            check("bp_dist",  {26'd0, out_dist}, 32'd8);
            check("bp_viol",  {31'd0, out_viol}, 32'd0);
        end
        check("bp_count", stat_count, 32'd6);
        in_valid  = 1'b0;
        take();
        check("bp_count_after", stat_count, 32'd6);

        // Clear coinciding with completion
        send(32'h000F_FFFF, 32'h0, 6'd12);
        repeat (3) tick();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_valid", {31'd0, out_valid}, 32'd1);
        check("clr_dist",  {26'd0, out_dist}, 32'd20);
        check("clr_count", stat_count, 32'd0);
        check("clr_sviol", stat_viol, 32'd0);
        check("clr_max",   {26'd0, stat_max}, 32'd0);
        take();
        send(32'h0000_001F, 32'h0, 6'd12);
        wait_result(lat);
        check("post_clr_dist",  {26'd0, out_dist}, 32'd5);
        check("post_clr_count", stat_count, 32'd1);
        check("post_clr_max",   {26'd0, stat_max}, 32'd5);
        check("post_clr_sviol", stat_viol, 32'd0);
        take();

        // Reset during the second accumulate cycle
        send(32'hFFFF_FFFF, 32'h0, 6'd12);
        tick();
        rst = 1'b1;
        #2;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_ready", {31'd0, in_ready}, 32'd1);
        check("arst_count", stat_count, 32'd0);
        check("arst_max",   {26'd0, stat_max}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_hold_ready", {31'd0, in_ready}, 32'd1);
        send(32'h0F0F_0F0F, 32'h0, 6'd12);
        wait_result(lat);
        check("post_rst_lat",   lat, 32'd4);
        check("post_rst_dist",  {26'd0, out_dist}, 32'd16);
        check("post_rst_viol",  {31'd0, out_viol}, 32'd1);
        check("post_rst_count", stat_count, 32'd1);
        take();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
